// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between echo, status and gesture responses.
// Gestures are queued, echo/status are held as pending flags, and one byte is in flight at a time.
module uart_tx_arbiter #(
  parameter int GESTURE_FIFO_DEPTH = 4,
  parameter int ACK_TIMEOUT        = 4,
  parameter int DROP_CNT_W         = 8
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  echo_req,
  input  logic                                  status_req,
  input  logic [2:0]                            status_bin,
  input  logic                                  gesture_valid,
  input  logic [1:0]                            gesture,
  output logic [7:0]                            tx_data,
  output logic                                  tx_valid,
  input  logic                                  tx_busy,
  output logic [$clog2(GESTURE_FIFO_DEPTH):0]   fifo_count,
  output logic [DROP_CNT_W-1:0]                 drop_count,
  output logic                                  idle
);

  localparam int PTR_W = $clog2(GESTURE_FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int TO_W  = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACK  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              state;
  state_t              state_next;
  logic [TO_W-1:0]     to_cnt;
  logic [TO_W-1:0]     to_cnt_next;
  logic [1:0]          echo_pend;
  logic                status_pend;
  logic [2:0]          stat_bin;
  logic [1:0]          fifo_mem [GESTURE_FIFO_DEPTH];
  logic [PTR_W-1:0]    rd_ptr;
  logic [PTR_W-1:0]    wr_ptr;
  logic                fifo_empty;
  logic                fifo_full;
  logic                issue_echo;
  logic                issue_status;
  logic                issue_gesture;
  logic                push;
  logic                drop;
  logic                tx_valid_next;
  logic [7:0]          tx_data_next;

  assign fifo_empty = (fifo_count == CNT_W'(0));
  assign fifo_full  = (fifo_count == CNT_W'(GESTURE_FIFO_DEPTH));

  // A pop frees a slot in the same cycle, so a push into a full FIFO is accepted then.
  assign push = gesture_valid && (!fifo_full || issue_gesture);
  assign drop = gesture_valid && fifo_full && !issue_gesture;

  assign idle = (state == S_IDLE) && (echo_pend == 2'd0) && !status_pend && fifo_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      to_cnt   <= '0;
      tx_valid <= 1'b0;
      tx_data  <= 8'h00;
    end else begin
      state    <= state_next;
      to_cnt   <= to_cnt_next;
      tx_valid <= tx_valid_next;
      tx_data  <= tx_data_next;
    end
  end

  always_comb begin
    state_next    = state;
    to_cnt_next   = to_cnt;
    tx_valid_next = 1'b0;
    tx_data_next  = tx_data;
    issue_echo    = 1'b0;
    issue_status  = 1'b0;
    issue_gesture = 1'b0;
    case (state)
      S_IDLE: begin
        // Fixed priority: echo > status > gesture.
        if (tx_busy) begin
          state_next = S_IDLE;
        end else if (echo_pend != 2'd0) begin
          issue_echo   = 1'b1;
          tx_data_next = 8'h55;
        end else if (status_pend) begin
          issue_status = 1'b1;
          tx_data_next = {4'hB, 1'b0, stat_bin};
        end else if (!fifo_empty) begin
          issue_gesture = 1'b1;
          tx_data_next  = {4'hA, 2'b00, fifo_mem[rd_ptr]};
        end else begin
          state_next = S_IDLE;
        end
        if (issue_echo || issue_status || issue_gesture) begin
          tx_valid_next = 1'b1;
          state_next    = S_ACK;
          to_cnt_next   = '0;
        end else begin
          tx_valid_next = 1'b0;
        end
      end
      S_ACK: begin
        // A transmitter that never acknowledges is treated as having sent the byte.
        if (tx_busy) begin
          state_next = S_DONE;
        end else if (to_cnt == TO_W'(ACK_TIMEOUT - 1)) begin
          state_next = S_IDLE;
        end else begin
          to_cnt_next = to_cnt + TO_W'(1);
        end
      end
      S_DONE: begin
        if (!tx_busy) begin
          state_next = S_IDLE;
        end else begin
          state_next = S_DONE;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      echo_pend <= 2'd0;
    end else begin
      case ({echo_req, issue_echo})
        2'b10: begin
          if (echo_pend != 2'd3) begin
            echo_pend <= echo_pend + 2'd1;
          end
        end
        2'b01:   echo_pend <= echo_pend - 2'd1;
        default: echo_pend <= echo_pend;
      endcase
    end
  end

  // A new request wins over the clear from a same-cycle issue.
  always_ff @(posedge clk) begin
    if (rst) begin
      status_pend <= 1'b0;
      stat_bin    <= 3'd0;
    end else if (status_req) begin
      status_pend <= 1'b1;
      stat_bin    <= status_bin;
    end else if (issue_status) begin
      status_pend <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_count <= '0;
      for (int i = 0; i < GESTURE_FIFO_DEPTH; i++) begin
        fifo_mem[i] <= 2'd0;
      end
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= gesture;
        wr_ptr           <= wr_ptr + PTR_W'(1);
      end
      if (issue_gesture) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, issue_gesture})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      drop_count <= '0;
    end else if (drop && (drop_count != {DROP_CNT_W{1'b1}})) begin
      drop_count <= drop_count + DROP_CNT_W'(1);
    end
  end

endmodule
